// File: rtl/rr_arb_ctrl.sv
// rr_arb_ctrl: round-robin arbiter controller for N requesters.
// Owns the one-hot circular priority pointer and a registered one-hot grant.
// A grant is held while its requester keeps req high. On release the
// pointer advances past the released requester, and the next winner is
// granted on the same edge (zero-bubble handover).
// Optional feature: define RR_HOLD_LIMIT_EN to force a release after
// MAX_HOLD consecutive grant cycles.
module rr_arb_ctrl #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic [N-1:0]   prior,
    output logic           ld_prior,
    output logic           ld_ng
);

    localparam int W2 = 2 * N;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_ARB,
        ST_GRANT
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   gnt_next;
    logic [N-1:0]   prior_next;
    logic           ld_prior_next;
    logic           ld_ng_next;

    logic [N-1:0]   rot_gnt;
    logic           owner_req;
    logic           hold_expired;
    logic           releasing;
    logic [N-1:0]   arb_ptr;
    logic [N-1:0]   below_ptr;
    logic [W2-1:0]  dbl_req;
    logic [W2-1:0]  first_dbl;
    logic [N-1:0]   win;
    logic           win_any;

    // Release detection and the pointer used for this edge's arbitration:
    // a releasing grant arbitrates against the already-advanced pointer.
    assign rot_gnt   = {gnt[N-2:0], gnt[N-1]};
    assign owner_req = |(req & gnt);
    assign releasing = (state == ST_GRANT) && (!owner_req || hold_expired);
    assign arb_ptr   = releasing ? rot_gnt : prior;

    // Double-width masked priority select: the upper copy holds all of req,
    // the lower copy only the bits at or above the pointer. Isolating the
    // lowest set bit and folding both halves gives the circular winner.
    assign below_ptr = arb_ptr - N'(1);
    assign dbl_req   = {req, req & ~below_ptr};
    assign first_dbl = dbl_req & (~dbl_req + W2'(1));
    assign win       = first_dbl[N-1:0] | first_dbl[W2-1:N];
    assign win_any   = |req;

`ifdef RR_HOLD_LIMIT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] hold_cnt_next;

    assign hold_expired = (hold_cnt == CW'(MAX_HOLD));

    // Hold counter: 1 on every new grant, counts grant cycles, clears when idle.
    always_comb begin
        hold_cnt_next = hold_cnt;
        if (ld_ng_next) begin
            hold_cnt_next = CW'(1);
        end else if (releasing) begin
            hold_cnt_next = '0;
        end else if (state == ST_GRANT) begin
            hold_cnt_next = hold_cnt + CW'(1);
        end
    end

    // Hold counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt_next;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    // Next-state, next-grant, next-pointer and strobe decode.
    always_comb begin
        state_next    = state;
        gnt_next      = gnt;
        prior_next    = prior;
        ld_prior_next = 1'b0;
        ld_ng_next    = 1'b0;
        case (state)
            ST_RESET, ST_ARB: begin
                if (win_any) begin
                    gnt_next   = win;
                    ld_ng_next = 1'b1;
                    state_next = ST_GRANT;
                end else begin
                    gnt_next   = '0;
                    state_next = ST_ARB;
                end
            end
            ST_GRANT: begin
                if (releasing) begin
                    prior_next    = rot_gnt;
                    ld_prior_next = 1'b1;
                    if (win_any) begin
                        gnt_next   = win;
                        ld_ng_next = 1'b1;
                    end else begin
                        gnt_next   = '0;
                        state_next = ST_ARB;
                    end
                end
            end
            default: begin
                state_next = ST_ARB;
                gnt_next   = '0;
            end
        endcase
    end

    // State, grant, pointer and strobe registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RESET;
            gnt      <= '0;
            prior    <= N'(1);
            ld_prior <= 1'b0;
            ld_ng    <= 1'b0;
        end else begin
            state    <= state_next;
            gnt      <= gnt_next;
            prior    <= prior_next;
            ld_prior <= ld_prior_next;
            ld_ng    <= ld_ng_next;
        end
    end

    // Binary index of the registered one-hot grant (0 when idle).
    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                gnt_id = gnt_id | IDW'(i);
            end
        end
    end

    assign gnt_valid = |gnt;

endmodule

// File: tb/tb_rr_arb_ctrl.sv
// tb_rr_arb_ctrl: directed bench for rr_arb_ctrl (N=4, MAX_HOLD=4).
// A reference model predicts each cycle's outputs when stimulus is driven;
// predictions are queued and popped for comparison one cycle later.
// Follows RR_HOLD_LIMIT_EN the same way the design does.
module tb_rr_arb_ctrl;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
    localparam int IDW      = 2;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic [N-1:0]   prior;
    logic           ld_prior;
    logic           ld_ng;

    typedef struct packed {
        logic [N-1:0]   gnt;
        logic           valid;
        logic [IDW-1:0] id;
        logic [N-1:0]   prior;
        logic           ldp;
        logic           ldng;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [N-1:0] m_gnt;
    logic [N-1:0] m_prior;
    logic         m_ldp;
    logic         m_ldng;
    int           m_cnt;

    rr_arb_ctrl #(.N(N), .MAX_HOLD(MAX_HOLD), .IDW(IDW)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .gnt      (gnt),
        .gnt_valid(gnt_valid),
        .gnt_id   (gnt_id),
        .prior    (prior),
        .ld_prior (ld_prior),
        .ld_ng    (ld_ng)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Circular search from the pointer position; -1 when nothing requested.
    function automatic int find_winner(input logic [N-1:0] r, input logic [N-1:0] p);
        int start;
        start = 0;
        for (int i = 0; i < N; i++) if (p[i]) start = i;
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    // Advance the reference model by one clock edge.
    task automatic model_step(input logic rst, input logic [N-1:0] r);
        int  w;
        bit  rel;
        bit  limit_on;
`ifdef RR_HOLD_LIMIT_EN
        limit_on = 1'b1;
`else
        limit_on = 1'b0;
`endif
        if (rst) begin
            m_gnt = '0; m_prior = 4'b0001; m_ldp = 0; m_ldng = 0; m_cnt = 0;
        end else begin
            m_ldp = 0;
            m_ldng = 0;
            if (m_gnt == '0) begin
                w = find_winner(r, m_prior);
                if (w >= 0) begin
                    m_gnt = 4'b0001 << w; m_ldng = 1; m_cnt = 1;
                end
            end else begin
                rel = ((r & m_gnt) == '0) || (limit_on && m_cnt == MAX_HOLD);
                if (rel) begin
                    m_prior = {m_gnt[N-2:0], m_gnt[N-1]};
                    m_ldp = 1;
                    w = find_winner(r, m_prior);
                    if (w >= 0) begin
                        m_gnt = 4'b0001 << w; m_ldng = 1; m_cnt = 1;
                    end else begin
                        m_gnt = '0; m_cnt = 0;
                    end
                end else begin
                    m_cnt++;
                end
            end
        end
    endtask

    // Compare one observed value against its requirement.
    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        assert (act === expv) else begin
            failures++;
            $error("[TB] FAIL %s actual=%0h expected=%0h", tag, act, expv);
        end
    endtask

    // Pop the oldest prediction and compare every DUT output.
    task automatic check_output(input string tag);
        exp_t e;
        checks++;
        assert (exp_q.size() > 0) else begin
            failures++;
            $error("[TB] FAIL %s scoreboard empty actual=0 expected=1", tag);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val({tag, ".gnt"},      32'(gnt),       32'(e.gnt));
            check_val({tag, ".valid"},    32'(gnt_valid), 32'(e.valid));
            check_val({tag, ".id"},       32'(gnt_id),    32'(e.id));
            check_val({tag, ".prior"},    32'(prior),     32'(e.prior));
            check_val({tag, ".ld_prior"}, 32'(ld_prior),  32'(e.ldp));
            check_val({tag, ".ld_ng"},    32'(ld_ng),     32'(e.ldng));
        end
    endtask

    // Drive one cycle of stimulus, queue the prediction, then check after the edge.
    task automatic apply_stimulus(input logic rst, input logic [N-1:0] r, input string tag);
        exp_t e;
        int   w;
        reset = rst;
        req   = r;
        model_step(rst, r);
        e.gnt   = m_gnt;
        e.valid = |m_gnt;
        w = find_winner(m_gnt, 4'b0001);
        e.id    = (w >= 0) ? IDW'(w) : '0;
        e.prior = m_prior;
        e.ldp   = m_ldp;
        e.ldng  = m_ldng;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_output(tag);
    endtask

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] exp_gnt;
        reset = 1'b1;
        req   = '0;
        m_gnt = '0; m_prior = 4'b0001; m_ldp = 0; m_ldng = 0; m_cnt = 0;
        #1;

        // Reset held for three cycles with all requesting
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 4'b1111, "reset");
        check_val("reset.gnt_lit", 32'(gnt), 32'h0);
        check_val("reset.prior_lit", 32'(prior), 32'h1);
        apply_stimulus(1'b0, 4'b1111, "reset_release");
        check_val("reset_release.gnt_lit", 32'(gnt), 32'h1);
        check_val("reset_release.ld_ng_lit", 32'(ld_ng), 32'h1);

        // Single requester grant and release into idle
        apply_stimulus(1'b1, 4'b0100, "single_rst");
        apply_stimulus(1'b0, 4'b0100, "single_grant");
        check_val("single.gnt_lit", 32'(gnt), 32'h4);
        check_val("single.id_lit", 32'(gnt_id), 32'h2);
        apply_stimulus(1'b0, 4'b0000, "single_drop");
        check_val("single_drop.gnt_lit", 32'(gnt), 32'h0);
        check_val("single_drop.prior_lit", 32'(prior), 32'h8);
        check_val("single_drop.ldp_lit", 32'(ld_prior), 32'h1);
        apply_stimulus(1'b0, 4'b0000, "single_idle");
        check_val("single_idle.ldp_lit", 32'(ld_prior), 32'h0);

        // Fairness: every requester holds two cycles then hands over
        apply_stimulus(1'b1, 4'b1111, "fair_rst");
        apply_stimulus(1'b0, 4'b1111, "fair_first");
        for (int k = 0; k < N; k++) begin
            apply_stimulus(1'b0, 4'b1111, "fair_hold");
            r = 4'b1111;
            r[k] = 1'b0;
            apply_stimulus(1'b0, r, "fair_handover");
            exp_gnt = 4'b0001 << ((k + 1) % N);
            check_val("fair.order_lit", 32'(gnt), 32'(exp_gnt));
        end

        // Handover with pointer wrap from requester 3 to requester 0
        apply_stimulus(1'b0, 4'b1000, "wrap_to3");
        apply_stimulus(1'b0, 4'b1001, "wrap_hold3");
        check_val("wrap.gnt3_lit", 32'(gnt), 32'h8);
        apply_stimulus(1'b0, 4'b0001, "wrap_drop3");
        check_val("wrap.gnt_lit", 32'(gnt), 32'h1);
        check_val("wrap.prior_lit", 32'(prior), 32'h1);
        check_val("wrap.ldp_lit", 32'(ld_prior), 32'h1);
        check_val("wrap.ldng_lit", 32'(ld_ng), 32'h1);

        // Two constant requesters: hold limit alternates, otherwise no change
        apply_stimulus(1'b1, 4'b0011, "hold_rst");
        for (int c = 0; c < 10; c++) begin
            apply_stimulus(1'b0, 4'b0011, "hold");
`ifdef RR_HOLD_LIMIT_EN
            exp_gnt = (((c / MAX_HOLD) % 2) != 0) ? 4'b0010 : 4'b0001;
`else
            exp_gnt = 4'b0001;
`endif
            check_val("hold.gnt_lit", 32'(gnt), 32'(exp_gnt));
        end

        // Reset in the middle of a grant
        apply_stimulus(1'b1, 4'b0010, "midrst_pre");
        apply_stimulus(1'b0, 4'b0010, "midrst_grant");
        apply_stimulus(1'b0, 4'b0010, "midrst_hold");
        apply_stimulus(1'b1, 4'b0010, "midrst_reset");
        check_val("midrst.gnt_lit", 32'(gnt), 32'h0);
        check_val("midrst.prior_lit", 32'(prior), 32'h1);
        apply_stimulus(1'b0, 4'b0010, "midrst_regrant");
        check_val("midrst.regrant_lit", 32'(gnt), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arb_ctrl.md
# rr_arb_ctrl

Parametrised round-robin arbiter controller for N requesters. It is the successor to the two-state next-grant/priority load controller. The block owns the circular priority pointer and a registered one-hot grant, and adds multi-cycle grant hold, zero-bubble handover and an optional hold-time limit. It keeps the `ld_prior`/`ld_ng` load strobes so the surrounding datapath can capture pointer and grant updates.

## Interface
- `N`, 4: number of requesters; N ≥ 2.
- `MAX_HOLD`, 8: maximum consecutive grant cycles per requester; used only under `RR_HOLD_LIMIT_EN`; ≥ 1.
- `IDW`, `$clog2(N)`: width of `gnt_id`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req` in N: request vector; `req[i]` high while requester i wants or holds the resource.
- `gnt` out N: registered one-hot grant, or all zeros.
- `gnt_valid` out 1: equals `|gnt`.
- `gnt_id` out IDW: binary index of the granted requester; 0 when `gnt_valid`=0.
- `prior` out N: one-hot priority pointer; the highest-priority requester for the next arbitration.
- `ld_prior` out 1: one-cycle strobe, high in the first cycle a new `prior` value is visible.
- `ld_ng` out 1: one-cycle strobe, high in the first cycle a new grant is visible.

## Operation
- **States:**
  - RESET: entered on any edge with `reset`=1.
  - ARB: no grant held.
  - GRANT: one requester holds the resource.
- **Reset values:**
  - `gnt`=0, `gnt_valid`=0, `gnt_id`=0.
  - `prior`=1 (bit 0).
  - `ld_prior`=0, `ld_ng`=0.
  - Hold counter = 0.
- **RESET:** on the first edge with `reset`=0, go to ARB. Arbitration may already occur on that edge if `req`≠0, matching ARB behaviour.
- **Arbitration function (winner):**
  - The winner is the first set bit of `req` scanning circularly upward from the `prior` position, inclusive.
  - Compute it as double-width masked priority select. No loops over time; purely combinational.
- **ARB:**
  - `req`=0: stay in ARB; `gnt` stays 0.
  - Otherwise: on the edge, load `gnt`=onehot(winner) and `gnt_id`, pulse `ld_ng`, and go to GRANT.
  - `prior` is unchanged on a grant from ARB.
- **GRANT, requester i holding:**
  - Hold while `req[i]`=1. Changes on other `req` bits are ignored.
- **GRANT, release (`req[i]`=0):**
  - On the edge: `prior` ← rotate-left-by-1 of `gnt` (requester i+1 mod N), and pulse `ld_prior`.
  - Arbitrate `req` against the new pointer in the same edge (zero-bubble handover):
    - Winner exists: new `gnt`, pulse `ld_ng`, stay in GRANT.
    - No winner: `gnt`=0, go to ARB.
- **Strobes:** `ld_prior` and `ld_ng` are registered and never high for two consecutive cycles unless there are two consecutive updates.
- **Reset mid-grant:** the next edge forces all reset values regardless of `req` or the hold state.
- **Pointer wrap:** rotating `gnt`[N-1] gives `prior`=1.

## Timing
- Request-to-grant latency: `req` sampled at edge t in ARB → `gnt` valid from t+1.
- Release-to-handover: `req[i]` falls before edge t → `gnt[i]`=0 and the new grant (if any) from t+1. `ld_prior`=1 at t+1, and `ld_ng`=1 at t+1 if a new grant is made.
- Minimum grant length: 1 cycle (request dropped right after the grant appears).
- `gnt`, `gnt_id`, `prior` and the strobes all update on the same edge. There are no combinational paths from `req` to any output.

## Configuration
- `RR_HOLD_LIMIT_EN` defined:
  - A hold counter loads 1 on each new grant and increments each GRANT cycle.
  - When the counter equals `MAX_HOLD` with `req[i]` still 1, the next edge performs a forced release, identical to a normal release.
  - If i is the only requester, it is re-granted: `ld_ng` and `ld_prior` pulse, the counter reloads 1, and `prior` = i+1.
- `RR_HOLD_LIMIT_EN` undefined:
  - No counter is implemented and `MAX_HOLD` is ignored.
  - A grant holds for as long as `req[i]`=1.

## Test plan
1. **Reset:** `reset`=1 for 3 cycles with `req`=1111 → `gnt`=0, `prior`=0001, strobes 0. Deassert `reset` → `gnt`=0001 at the next cycle with `ld_ng`=1.
2. **Single requester:** `req`=0100 from `prior`=0001 → `gnt`=0100, `gnt_id`=2 one cycle later. Drop `req` → `gnt`=0, `prior`=1000, `ld_prior`=1 for 1 cycle, state ARB.
3. **Fairness:** `req`=1111, each granted requester drops `req` 2 cycles after its grant and then re-raises it → grant order 0,1,2,3,0 with no idle cycles between grants.
4. **Handover and wrap:** `gnt`=1000 with `req`=1001; drop `req[3]` → next cycle `gnt`=0001, `prior`=0001, and `ld_prior`=`ld_ng`=1 together.
5. **Hold limit:** `RR_HOLD_LIMIT_EN` defined, `MAX_HOLD`=4, `req`=0011 constant → `gnt`=0001 for 4 cycles, then 0010 for 4 cycles, alternating. With the macro undefined → `gnt`=0001 indefinitely.
6. **Reset mid-grant:** `gnt`=0010 with `req`=0010; assert `reset` for 1 cycle → `gnt`=0 and `prior`=0001 on that edge, then `gnt`=0010 again one cycle after deassertion.
